dmem_unloader: RTL and testbench

Streams a contiguous block of result words out of the core's data memory over a valid/ready stream. It sits beside the single-cycle RISC-V core on the data-memory read port and is used after an FFT/IFFT program finishes, so that results leave the design by hardware instead of hierarchical peeking. The block is the reader counterpart to the instruction-memory loading path: it takes a start command, base address and word count, issues synchronous memory reads, and buffers the returned data against downstream back-pressure.

---
 rtl/dmem_unloader.sv | 164 ++++++++++++++++
 tb/tb_dmem_unloader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_unloader.sv
// Streams a block of words out of data memory over a valid/ready interface.
// Synchronous one-cycle-latency reads feed a 2-entry FIFO that absorbs back-pressure.
module dmem_unloader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [CNT_WIDTH-1:0]  r_remaining;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [1:0]            r_count;
  logic [DATA_WIDTH-1:0] r_data0;
  logic [DATA_WIDTH-1:0] r_data1;
  logic                  r_last0;
  logic                  r_last1;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [2:0]            w_occ;
  logic [1:0]            w_slot;
  logic [1:0]            w_count_n;
  logic [DATA_WIDTH-1:0] w_data0_n;
  logic [DATA_WIDTH-1:0] w_data1_n;
  logic                  w_last0_n;
  logic                  w_last1_n;
  logic [ADDR_WIDTH-1:0] w_base_aligned;

  assign w_base_aligned = base_addr & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  // Words issued but not yet accepted = FIFO occupancy + read in flight; keep it at most 2.
  assign w_pop   = (r_count != 2'd0) && out_ready;
  assign w_push  = r_inflight;
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_issue = (r_state == S_RUN) && (r_remaining != {CNT_WIDTH{1'b0}}) &&
                   (w_occ < (3'd2 + {2'b00, w_pop}));
  assign w_slot  = r_count - {1'b0, w_pop};

  assign mem_rd_en = w_issue;
  assign mem_addr  = w_issue ? r_addr : r_mem_addr;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_data0;
  assign out_last  = r_last0 && (r_count != 2'd0);
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_FIN);

  // Next-state logic for the transfer sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (word_count != {CNT_WIDTH{1'b0}}) ? S_RUN : S_FIN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_pop && r_last0) begin
          w_state_nxt = S_FIN;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO update: pop shifts the tail to the head, push lands in the first free slot after that.
  always_comb begin
    w_data0_n = r_data0;
    w_data1_n = r_data1;
    w_last0_n = r_last0;
    w_last1_n = r_last1;
    if (w_pop) begin
      w_data0_n = r_data1;
      w_last0_n = r_last1;
    end else begin
      w_data0_n = r_data0;
      w_last0_n = r_last0;
    end
    if (w_push) begin
      if (w_slot == 2'd0) begin
        w_data0_n = mem_rd_data;
        w_last0_n = r_inflight_last;
      end else begin
        w_data1_n = mem_rd_data;
        w_last1_n = r_inflight_last;
      end
    end else begin
      w_data1_n = r_data1;
    end
    case ({w_push, w_pop})
      2'b10:   w_count_n = r_count + 2'd1;
      2'b01:   w_count_n = r_count - 2'd1;
      default: w_count_n = r_count;
    endcase
  end

  // State, address/remaining counters, in-flight tracking and FIFO storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_addr          <= {ADDR_WIDTH{1'b0}};
      r_mem_addr      <= {ADDR_WIDTH{1'b0}};
      r_remaining     <= {CNT_WIDTH{1'b0}};
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_count         <= 2'd0;
      r_data0         <= {DATA_WIDTH{1'b0}};
      r_data1         <= {DATA_WIDTH{1'b0}};
      r_last0         <= 1'b0;
      r_last1         <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      r_count    <= w_count_n;
      r_data0    <= w_data0_n;
      r_data1    <= w_data1_n;
      r_last0    <= w_last0_n;
      r_last1    <= w_last1_n;
      if ((r_state == S_IDLE) && start) begin
        r_addr      <= w_base_aligned;
        r_remaining <= word_count;
      end else if (w_issue) begin
        r_addr          <= r_addr + {{(ADDR_WIDTH-3){1'b0}}, 3'd4};
        r_remaining     <= r_remaining - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        r_mem_addr      <= r_addr;
        r_inflight_last <= (r_remaining == {{(CNT_WIDTH-1){1'b0}}, 1'b1});
      end else begin
        r_addr      <= r_addr;
        r_remaining <= r_remaining;
      end
    end
  end

endmodule

// File: tb/tb_dmem_unloader.sv
// Scoreboard bench for dmem_unloader: stimulus queues expected reads/words, a negedge monitor checks them.
module tb_dmem_unloader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  dmem_unloader #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int c0 = 0;
  int n_issued = 0;
  int n_accepted = 0;
  int first_rd_rel = -1;
  int first_out_rel = -1;
  int done_rel = -1;
  int done_cnt = 0;
  int exp_done = 0;
  int ready_mode = 0;
  bit busy_seen = 1'b0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_data = 32'd0;

  logic [31:0] mem [logic [31:0]];
  logic [32:0] exp_q [$];
  logic [31:0] addr_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {~a[15:0], a[15:0]};
  endfunction

  // Behavioural memory: data appears one cycle after the read request.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_word(mem_addr);

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp_v, cyc);
  endtask

  // Downstream ready pattern: 0 hold high, 1 toggle, 2 random, 3 hold low.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        2: out_ready = ($urandom_range(0, 99) < 60);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares reads and stream words against the queued expectations.
  always @(negedge clk) begin
    logic [32:0] e;
    logic [31:0] a;
    int pend;
    if (!rst) begin
      if (mem_rd_en) begin
        if (n_issued == 0) first_rd_rel = cyc - c0;
        pend = n_issued - n_accepted - ((out_valid && out_ready) ? 1 : 0);
        chk(pend < 2, "no_overflow", 32'(pend), 32'd1);
        if (addr_q.size() == 0) chk(1'b0, "extra_read", mem_addr, 32'd0);
        else begin
          a = addr_q.pop_front();
          chk(mem_addr == a, "rd_addr", mem_addr, a);
        end
        n_issued++;
      end
      if (out_valid && first_out_rel < 0) first_out_rel = cyc - c0;
      if (prev_stall) chk(out_valid && out_data == prev_data, "stall_stable", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk(1'b0, "extra_word", out_data, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk(out_data == e[31:0], "out_data", out_data, e[31:0]);
          chk(out_last == e[32], "out_last", {31'd0, out_last}, {31'd0, e[32]});
        end
        n_accepted++;
      end
      if (busy) busy_seen = 1'b1;
      if (done) begin
        chk(exp_done > 0, "done_expected", 32'd1, 32'd0);
        chk(exp_q.size() == 0 && !busy, "done_after_last", 32'(exp_q.size()), 32'd0);
        if (exp_done > 0) exp_done--;
        done_cnt++;
        done_rel = cyc - c0;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic do_start(input logic [31:0] b, input int n);
    logic [31:0] a;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_count = n[15:0];
    c0 = cyc; n_issued = 0; n_accepted = 0;
    first_rd_rel = -1; first_out_rel = -1; done_rel = -1; busy_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = (b & 32'hFFFF_FFFC) + 32'(4 * i);
      addr_q.push_back(a);
      exp_q.push_back({(i == n - 1), mem_word(a)});
    end
    exp_done++;
    @(posedge clk); #1;
    start = 1'b0; base_addr = $urandom; word_count = 16'($urandom);
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 400; k++) begin
      @(posedge clk);
      if (exp_done == 0) break;
    end
    if (k >= 400) chk(1'b0, name, 32'(exp_done), 32'd0);
  endtask

  task automatic chk_reset_vals();
    chk(mem_rd_en == 1'b0, "rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk(mem_addr == 32'd0, "rst_addr", mem_addr, 32'd0);
    chk(out_valid == 1'b0, "rst_valid", {31'd0, out_valid}, 32'd0);
    chk(out_data == 32'd0, "rst_data", out_data, 32'd0);
    chk(out_last == 1'b0, "rst_last", {31'd0, out_last}, 32'd0);
    chk(busy == 1'b0, "rst_busy", {31'd0, busy}, 32'd0);
    chk(done == 1'b0, "rst_done", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int k;
    int dc;
    rst = 1'b1; start = 1'b0; base_addr = 32'd0; word_count = 16'd0; mem_rd_data = 32'd0;
    mem[32'h100] = 32'd11; mem[32'h104] = 32'd22; mem[32'h108] = 32'd33; mem[32'h10C] = 32'd44;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk); #1; rst = 1'b0;

    // Basic 4-word block, ready held high: exact cycle timing.
    ready_mode = 0;
    do_start(32'h100, 4);
    wait_done("timeout_basic");
    chk(first_rd_rel == 1, "first_rd_cycle", 32'(first_rd_rel), 32'd1);
    chk(first_out_rel == 3, "first_valid_cycle", 32'(first_out_rel), 32'd3);
    chk(done_rel == 7, "done_cycle", 32'(done_rel), 32'd7);
    chk(n_issued == 4, "basic_reads", 32'(n_issued), 32'd4);

    // Same block with toggling ready.
    ready_mode = 1;
    do_start(32'h100, 4);
    wait_done("timeout_toggle");

    // Ready low for 10 cycles: only two reads may be outstanding.
    ready_mode = 3;
    do_start(32'h200, 8);
    repeat (9) @(posedge clk);
    chk(n_issued == 2, "stalled_reads", 32'(n_issued), 32'd2);
    #1 ready_mode = 0;
    wait_done("timeout_stall");
    chk(n_accepted == 8, "stall_words", 32'(n_accepted), 32'd8);

    // Zero-length block.
    do_start(32'h300, 0);
    wait_done("timeout_zero");
    chk(done_rel == 1, "zero_done_cycle", 32'(done_rel), 32'd1);
    chk(busy_seen == 1'b0, "zero_busy", {31'd0, busy_seen}, 32'd0);
    chk(n_issued == 0, "zero_reads", 32'(n_issued), 32'd0);

    // Unaligned base and address wrap.
    do_start(32'h103, 1);
    wait_done("timeout_unaligned");
    do_start(32'hFFFF_FFFC, 2);
    wait_done("timeout_wrap");

    // Start pulsed mid-transfer is ignored.
    ready_mode = 1;
    do_start(32'h100, 4);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h500; word_count = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("timeout_ignored_start");

    // Reset after 3 words of a 6-word block.
    ready_mode = 0;
    do_start(32'h400, 6);
    for (k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (n_accepted >= 3) break;
    end
    if (k >= 100) chk(1'b0, "timeout_pre_reset", 32'(n_accepted), 32'd3);
    dc = done_cnt;
    rst = 1'b1;
    addr_q.delete(); exp_q.delete(); exp_done = 0;
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk); #1; rst = 1'b0;
    repeat (6) @(posedge clk);
    chk(done_cnt == dc, "no_done_after_reset", 32'(done_cnt), 32'(dc));
    do_start(32'h600, 5);
    wait_done("timeout_after_reset");

    // Randomized blocks with random back-pressure.
    ready_mode = 2;
    for (int t = 0; t < 15; t++) begin
      do_start($urandom, $urandom_range(0, 12));
      wait_done("timeout_random");
    end

    chk(exp_q.size() == 0, "words_left", 32'(exp_q.size()), 32'd0);
    chk(addr_q.size() == 0, "reads_left", 32'(addr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
